// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder
//   Two-stage pipelined carry-select adder/subtractor with a valid/ready stream
//   on both sides. Operands are cut into BLK-bit blocks. Stage 1 computes every
//   block's sum for both possible block carry-ins. Stage 2 walks the short
//   block-carry chain and picks one hypothesis per block.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of BLK
//   BLK    carry-select block width, 1 <= BLK <= WIDTH (BLK == WIDTH is a plain ripple adder)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; drops in-flight beats
//   in_valid   operand beat valid
//   in_ready   beat accepted on this edge if in_valid (combinational from out_ready)
//   a, b       operands
//   cin        carry-in, add mode only
//   sub        0: a+b+cin   1: a-b (a + ~b + 1, cin ignored)
//   out_valid  result beat valid; held with its data until out_ready
//   out_ready  consumer takes the result this cycle
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement overflow
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB = WIDTH / BLK;

  generate
    if (BLK < 1 || BLK > WIDTH || (WIDTH % BLK) != 0) begin : g_param_check
      $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLK");
    end
  endgenerate

  // ---------------------------------------------------------------- handshake
  logic s1_valid;
  logic s2_valid;
  logic adv1;
  logic adv2;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------- stage 1 comb
  logic [WIDTH-1:0]         b_eff;
  logic                     cin_eff;
  logic [NB-1:0][BLK-1:0]   s0_next;
  logic [NB-1:0][BLK-1:0]   s1_next;
  logic [NB-1:0]            c0_next;
  logic [NB-1:0]            c1_next;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
      if (gi == 0) begin : g_first
        // Block 0 already knows its real carry-in; both hypothesis slots carry
        // the same value so the stage-2 select is a no-op here.
        assign {c0_next[gi], s0_next[gi]} = {1'b0, a[gi*BLK +: BLK]}
                                          + {1'b0, b_eff[gi*BLK +: BLK]}
                                          + {{BLK{1'b0}}, cin_eff};
        assign {c1_next[gi], s1_next[gi]} = {c0_next[gi], s0_next[gi]};
      end else begin : g_rest
        assign {c0_next[gi], s0_next[gi]} = {1'b0, a[gi*BLK +: BLK]}
                                          + {1'b0, b_eff[gi*BLK +: BLK]};
        assign {c1_next[gi], s1_next[gi]} = {1'b0, a[gi*BLK +: BLK]}
                                          + {1'b0, b_eff[gi*BLK +: BLK]}
                                          + {{BLK{1'b0}}, 1'b1};
      end
    end
  endgenerate

  // ---------------------------------------------------------------- stage 1 regs
  logic [NB-1:0][BLK-1:0]   s0_reg;
  logic [NB-1:0][BLK-1:0]   s1_reg;
  logic [NB-1:0]            c0_reg;
  logic [NB-1:0]            c1_reg;
  logic                     cin_reg;
  logic                     a_msb_reg;
  logic                     b_msb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
    end
  end

  // Data path registers need no reset: they are only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s0_reg    <= s0_next;
      s1_reg    <= s1_next;
      c0_reg    <= c0_next;
      c1_reg    <= c1_next;
      cin_reg   <= cin_eff;
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b_eff[WIDTH-1];
    end
  end

  // ---------------------------------------------------------------- stage 2 comb
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;

  // Block-carry chain: NB two-input muxes in series instead of a WIDTH-bit ripple.
  always_comb begin
    logic carry;
    carry    = cin_reg;
    sum_next = '0;
    for (int k = 0; k < NB; k++) begin
      sum_next[k*BLK +: BLK] = carry ? s1_reg[k] : s0_reg[k];
      carry                  = carry ? c1_reg[k] : c0_reg[k];
    end
    cout_next = carry;
  end

  // Carry into the MSB is recovered from the MSB sum bit and its two operands.
  assign ovf_next = cout_next ^ (sum_next[WIDTH-1] ^ a_msb_reg ^ b_msb_reg);

  // ---------------------------------------------------------------- stage 2 regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_next;
        cout <= cout_next;
        ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Testbench for pipelined_csel_adder (WIDTH=16, BLK=4).
// A negedge monitor pushes the expected {ovf,cout,sum} of every accepted beat
// into a queue and pops/compares on every consumed result; it also checks that a
// stalled output holds. Directed table, latency, stall, reset and random traffic.
module tb_pipelined_csel_adder;

  localparam int W = 16;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(W), .BLK(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  int total = 0;
  int bad   = 0;
  int nout  = 0;

  logic [W+1:0] expq[$];
  logic [W+1:0] cur_exp = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Independent reference: wide add, ovf from operand/result sign agreement.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         v;
    be = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
    v  = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
    return {v, r};
  endfunction

  // ------------------------------------------------------------ monitor
  logic         stall_prev = 1'b0;
  logic [W+1:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({ovf, cout, sum}), 32'(held));
      end
      if (out_valid && out_ready) begin
        nout++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got=%h want=none", {ovf, cout, sum});
        end else begin
          logic [W+1:0] e;
          e = expq.pop_front();
          check("result", 32'({ovf, cout, sum}), 32'(e));
          $display("out %0d: sum=%h cout=%b ovf=%b", nout, sum, cout, ovf);
        end
      end
      if (in_valid && in_ready) expq.push_back(cur_exp);
      stall_prev = out_valid && !out_ready;
      held       = {ovf, cout, sum};
    end
  end

  // ------------------------------------------------------------ driver helpers
  // Present a beat and wait for its acceptance edge; returns at edge+1.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic ts, input logic [W+1:0] te);
    logic ok;
    ok = 1'b0;
    a = ta; b = tb; cin = tc; sub = ts; cur_exp = te;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got=no_accept want=accept");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs, acc;
    int           sent;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h0FFF, 16'hF001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({ovf, cout, sum}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: result appears on the second edge after the accepting one's cycle
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    in_valid = 1'b0;
    check("lat_stage1_only", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    drain();

    // Directed table, back-to-back with the consumer always ready
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
           {vecs[i].eovf, vecs[i].ecout, vecs[i].esum});
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      $display("in %0d: a=%h b=%h cin=%b sub=%b", i, vecs[i].va, vecs[i].vb,
               vecs[i].vcin, vecs[i].vsub);
    end
    drain();

    // Stall: two beats fill the pipe, third is held off, then all drain in order
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    send(16'h3333, 16'h0444, 1'b0, 1'b1, model(16'h3333, 16'h0444, 1'b0, 1'b1));
    check("full_in_ready", 32'(in_ready), 32'd0);
    a = 16'hABCD; b = 16'h5432; cin = 1'b1; sub = 1'b0;
    cur_exp  = model(16'hABCD, 16'h5432, 1'b1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("comb_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Reset with both stages full drops everything
    out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, model(16'h0F0F, 16'h0101, 1'b0, 1'b0));
    send(16'h7000, 16'h1000, 1'b0, 1'b0, model(16'h7000, 16'h1000, 1'b0, 1'b0));
    in_valid = 1'b0;
    check("pre_rst_full", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_outputs", 32'({ovf, cout, sum}), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    expq.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("no_stale_beat", 32'(out_valid), 32'd0);
    end

    // Random traffic with random producer/consumer stalls
    sent = 0;
    acc  = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          ra = W'($urandom);
          rb = W'($urandom);
          if ($urandom_range(0, 7) == 0) ra = '1;
          if ($urandom_range(0, 7) == 0) rb = '0;
          rc = 1'($urandom);
          rs = 1'($urandom);
          a = ra; b = rb; cin = rc; sub = rs;
          cur_exp  = model(ra, rb, rc, rs);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
    end
    check("rand_sent", 32'(sent), 32'd10000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
